tlul_reg_responder: RTL

- TL-UL device-side endpoint: terminates a TL-UL A channel and returns exactly one D-channel response per request.
- Converts each request to single-cycle read/write strobes on a simple register interface.
- Sits at the device end of a TL-UL link, after the crossbar and any elasticity FIFO, in front of register files.
- One outstanding transaction; all A-channel protocol errors are detected and answered locally.

---
 rtl/tlul_pkg.sv | 40 ++++
 rtl/tlul_req_chk.sv | 22 ++
 rtl/tlul_reg_responder.sv | 75 +++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// tlul_pkg: shared TL-UL channel types, widths and opcodes
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;
  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;
  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tlul_h2d_t;
  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tlul_d2h_t;
endpackage

// File: rtl/tlul_req_chk.sv
// tlul_req_chk: combinational legality check of a TL-UL A-channel request
module tlul_req_chk
  import tlul_pkg::*;
(
  input  logic [2:0]        a_opcode,
  input  logic [TL_SZW-1:0] a_size,
  input  logic [1:0]        a_address,
  input  logic [TL_DBW-1:0] a_mask,
  output logic              err_o
);
  logic [TL_DBW-1:0] lanes;
  logic bad_op, bad_size, misaligned, stray, bad_full, empty_get;
  assign lanes      = a_size == 2'd0 ? 4'b0001 << a_address :
                      a_size == 2'd1 ? 4'b0011 << a_address : 4'b1111;
  assign bad_op     = !(a_opcode == Get || a_opcode == PutFullData || a_opcode == PutPartialData);
  assign bad_size   = a_size > 2'd2;
  assign misaligned = (a_size == 2'd1 && a_address[0]) || (a_size == 2'd2 && a_address != 2'd0);
  assign stray      = |(a_mask & ~lanes);
  assign bad_full   = a_opcode == PutFullData && a_mask != lanes;
  assign empty_get  = a_opcode == Get && a_mask == '0;
  assign err_o      = bad_op | bad_size | misaligned | stray | bad_full | empty_get;
endmodule

// File: rtl/tlul_reg_responder.sv
// tlul_reg_responder: TL-UL device endpoint driving single-cycle register strobes
module tlul_reg_responder
  import tlul_pkg::*;
#(
  parameter int RegAw = 8,
  parameter int RegDw = TL_DW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tlul_h2d_t          tl_i,
  output tlul_d2h_t          tl_o,
  output logic               re_o,
  output logic               we_o,
  output logic [RegAw-1:0]   addr_o,
  output logic [RegDw-1:0]   wdata_o,
  output logic [RegDw/8-1:0] be_o,
  input  logic [RegDw-1:0]   rdata_i,
  input  logic               error_i
);
  localparam logic [1:0] IDLE = 2'd0, RD_WAIT = 2'd1, RESP = 2'd2;
  logic [1:0]        state;
  logic              up, a_rdy, acc, chk_err, is_get, unused_tl;
  logic [2:0]        rsp_op;
  logic [TL_SZW-1:0] rsp_size;
  logic [TL_AIW-1:0] rsp_src;
  logic              rsp_err;
  logic [TL_DW-1:0]  rsp_data;
  tlul_req_chk u_chk (
    .a_opcode (tl_i.a_opcode),
    .a_size   (tl_i.a_size),
    .a_address(tl_i.a_address[1:0]),
    .a_mask   (tl_i.a_mask),
    .err_o    (chk_err)
  );
  // up holds a_ready low for the first cycle after reset
  assign a_rdy     = up & ~rst_i & (state == IDLE);
  assign acc       = a_rdy & tl_i.a_valid;
  assign is_get    = tl_i.a_opcode == Get;
  assign re_o      = acc & ~chk_err & is_get;
  assign we_o      = acc & ~chk_err & ~is_get;
  assign addr_o    = (re_o | we_o) ? {tl_i.a_address[RegAw-1:2], 2'b00} : '0;
  assign wdata_o   = we_o ? tl_i.a_data : '0;
  assign be_o      = (re_o | we_o) ? tl_i.a_mask : '0;
  assign unused_tl = ^tl_i;
  assign tl_o = '{d_valid: ~rst_i & (state == RESP), d_opcode: rsp_op, d_param: '0,
                  d_size: rsp_size, d_source: rsp_src, d_sink: '0, d_data: rsp_data,
                  d_error: rsp_err, a_ready: a_rdy};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      up       <= 1'b0;
      rsp_op   <= '0;
      rsp_size <= '0;
      rsp_src  <= '0;
      rsp_err  <= 1'b0;
      rsp_data <= '0;
    end else begin
      up <= 1'b1;
      if (acc) begin
        rsp_op   <= is_get ? AccessAckData : AccessAck;
        rsp_size <= tl_i.a_size;
        rsp_src  <= tl_i.a_source;
        rsp_err  <= chk_err | (we_o & error_i);
        rsp_data <= (is_get & chk_err) ? '1 : '0;
        state    <= re_o ? RD_WAIT : RESP;
      end else if (state == RD_WAIT) begin
        rsp_err  <= error_i;
        rsp_data <= error_i ? '1 : rdata_i;
        state    <= RESP;
      end else if (state == RESP && tl_i.d_ready) begin
        state <= IDLE;
      end
    end
  end
endmodule
